// File: rtl/axis_user_rx_checker.sv
// axis_user_rx_checker: checks received AXI-Stream user packets against the
// incrementing-byte pattern and length. Optional idle abort: AXIS_CHK_TIMEOUT_EN.
module axis_user_rx_checker #(
    parameter int P_MAX_LEN = 1472,
    parameter int P_TIMEOUT = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [63:0] s_axis_tdata,
    input  logic [31:0] s_axis_tuser,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic        o_pkt_done,
    output logic        o_pkt_ok,
    output logic [31:0] o_pkt_cnt,
    output logic [31:0] o_err_cnt,
    output logic [2:0]  o_err_code,
    output logic        o_err_flag,
    output logic [15:0] o_last_len
);

    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_RECV  = 2'd1;
    localparam logic [1:0]  S_DRAIN = 2'd2;
    localparam logic [16:0] MAX_LEN = 17'(P_MAX_LEN);

    logic [1:0]  state_q, state_d;
    logic [15:0] k_q, k_d;
    logic [15:0] len_q, len_d;
    logic [2:0]  pend_q, pend_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [31:0] err_cnt_q, err_cnt_d;
    logic [2:0]  err_code_q, err_code_d;
    logic        err_flag_q, err_flag_d;
    logic [15:0] last_len_q, last_len_d;

    logic [15:0] k_base, len_eff, k_next;
    logic [16:0] k_sum;
    logic [3:0]  pop;
    logic [7:0]  nkeep, nkeep_inc;
    logic        data_err, keep_err, over_err;
    logic [2:0]  beat_code;

    logic [15:0] unused_tuser;
    assign unused_tuser = s_axis_tuser[15:0];

`ifdef AXIS_CHK_TIMEOUT_EN
    logic [31:0] idle_q, idle_d;
`else
    logic [31:0] unused_tmo;
    assign unused_tmo = 32'(P_TIMEOUT);
`endif

    // Evaluate the current beat: pattern, keep shape, byte index and error code
    always_comb begin
        k_base   = (state_q == S_IDLE) ? 16'd0 : k_q;
        len_eff  = (state_q == S_IDLE) ? s_axis_tuser[31:16] : len_q;
        pop      = 4'd0;
        data_err = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (s_axis_tkeep[7-j]) begin
                pop = pop + 4'd1;
                if (s_axis_tdata[63-8*j -: 8] != k_base[7:0] + 8'(j))
                    data_err = 1'b1;
            end
        end
        k_sum     = {1'b0, k_base} + {13'd0, pop};
        k_next    = k_sum[16] ? 16'hFFFF : k_sum[15:0];
        nkeep     = ~s_axis_tkeep;
        nkeep_inc = nkeep + 8'd1;
        keep_err  = (s_axis_tkeep == 8'h00) ||
                    (s_axis_tlast ? ((nkeep & nkeep_inc) != 8'h00)
                                  : (s_axis_tkeep != 8'hFF));
        over_err  = {1'b0, k_next} > MAX_LEN;
        if (keep_err)
            beat_code = 3'd2;
        else if (data_err)
            beat_code = 3'd1;
        else if (over_err)
            beat_code = 3'd4;
        else if (s_axis_tlast && (k_next != len_eff))
            beat_code = 3'd3;
        else
            beat_code = 3'd0;
    end

    // Packet FSM and completion bookkeeping
    always_comb begin
        logic       fin;
        logic [2:0] fin_code;
        fin        = 1'b0;
        fin_code   = 3'd0;
        state_d    = state_q;
        k_d        = k_q;
        len_d      = len_q;
        pend_d     = pend_q;
        done_d     = 1'b0;
        ok_d       = 1'b0;
        pkt_cnt_d  = pkt_cnt_q;
        err_cnt_d  = err_cnt_q;
        err_code_d = err_code_q;
        err_flag_d = err_flag_q;
        last_len_d = last_len_q;
`ifdef AXIS_CHK_TIMEOUT_EN
        idle_d     = 32'd0;
`endif
        case (state_q)
            S_IDLE: begin
                if (s_axis_tvalid) begin
                    len_d  = s_axis_tuser[31:16];
                    k_d    = k_next;
                    pend_d = beat_code;
                    if (s_axis_tlast) begin
                        fin      = 1'b1;
                        fin_code = beat_code;
                    end else if (beat_code != 3'd0) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_RECV;
                    end
                end
            end
            S_RECV: begin
                if (s_axis_tvalid) begin
                    k_d = k_next;
                    if (s_axis_tlast) begin
                        fin      = 1'b1;
                        fin_code = beat_code;
                        state_d  = S_IDLE;
                    end else if (beat_code != 3'd0) begin
                        pend_d  = beat_code;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    fin      = 1'b1;
                    fin_code = pend_q;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef AXIS_CHK_TIMEOUT_EN
        if ((state_q != S_IDLE) && !s_axis_tvalid) begin
            if (idle_q == 32'(P_TIMEOUT - 1)) begin
                fin      = 1'b1;
                fin_code = 3'd5;
                state_d  = S_IDLE;
            end else begin
                idle_d = idle_q + 32'd1;
            end
        end
`endif
        if (fin) begin
            done_d     = 1'b1;
            pkt_cnt_d  = pkt_cnt_q + 32'd1;
            last_len_d = k_d;
            if (fin_code == 3'd0) begin
                ok_d = 1'b1;
            end else begin
                err_cnt_d  = err_cnt_q + 32'd1;
                err_code_d = fin_code;
                err_flag_d = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            k_q        <= 16'd0;
            len_q      <= 16'd0;
            pend_q     <= 3'd0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            pkt_cnt_q  <= 32'd0;
            err_cnt_q  <= 32'd0;
            err_code_q <= 3'd0;
            err_flag_q <= 1'b0;
            last_len_q <= 16'd0;
`ifdef AXIS_CHK_TIMEOUT_EN
            idle_q     <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            len_q      <= len_d;
            pend_q     <= pend_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            pkt_cnt_q  <= pkt_cnt_d;
            err_cnt_q  <= err_cnt_d;
            err_code_q <= err_code_d;
            err_flag_q <= err_flag_d;
            last_len_q <= last_len_d;
`ifdef AXIS_CHK_TIMEOUT_EN
            idle_q     <= idle_d;
`endif
        end
    end

    assign o_pkt_done = done_q;
    assign o_pkt_ok   = ok_q;
    assign o_pkt_cnt  = pkt_cnt_q;
    assign o_err_cnt  = err_cnt_q;
    assign o_err_code = err_code_q;
    assign o_err_flag = err_flag_q;
    assign o_last_len = last_len_q;

endmodule

// File: tb/tb_axis_user_rx_checker.sv
// tb_axis_user_rx_checker: directed packets with hand-computed status,
// counters and error codes; timeout case follows AXIS_CHK_TIMEOUT_EN.
module tb_axis_user_rx_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] tdata;
    logic [31:0] tuser;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        pkt_done, pkt_ok, err_flag;
    logic [31:0] pkt_cnt, err_cnt;
    logic [2:0]  err_code;
    logic [15:0] last_len;

    int n_checks = 0;
    int n_err    = 0;

    axis_user_rx_checker #(.P_MAX_LEN(1472), .P_TIMEOUT(16)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .s_axis_tdata  (tdata),
        .s_axis_tuser  (tuser),
        .s_axis_tkeep  (tkeep),
        .s_axis_tlast  (tlast),
        .s_axis_tvalid (tvalid),
        .o_pkt_done    (pkt_done),
        .o_pkt_ok      (pkt_ok),
        .o_pkt_cnt     (pkt_cnt),
        .o_err_cnt     (err_cnt),
        .o_err_code    (err_code),
        .o_err_flag    (err_flag),
        .o_last_len    (last_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [63:0] d, input logic [7:0] kp,
                         input logic l, input int len);
        tdata  = d;
        tkeep  = kp;
        tlast  = l;
        tuser  = {len[15:0], 16'h1234};
        tvalid = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle_cyc();
        tvalid = 1'b0;
        tlast  = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_beats(input int nbytes, input int len, input int b0,
                              input int b1, input int cidx,
                              input logic [7:0] cval);
        int nb;
        nb = (nbytes + 7) / 8;
        for (int b = b0; b < b1; b++) begin
            logic [63:0] d;
            logic [7:0]  kp;
            d  = '0;
            kp = '0;
            for (int j = 0; j < 8; j++) begin
                int idx;
                idx = b * 8 + j;
                if (idx < nbytes) begin
                    kp[7-j] = 1'b1;
                    d[63-8*j -: 8] = (idx == cidx) ? cval : 8'(idx);
                end
            end
            drive(d, kp, (b == nb - 1), len);
        end
    endtask

    task automatic send_pkt(input int nbytes, input int len);
        send_beats(nbytes, len, 0, (nbytes + 7) / 8, -1, 8'h00);
    endtask

    initial begin
        rst_n  = 1'b0;
        tdata  = '0;
        tuser  = '0;
        tkeep  = '0;
        tlast  = 1'b0;
        tvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(pkt_done), 32'd0);
        chk("rst_pkt_cnt", pkt_cnt, 32'd0);
        chk("rst_err_cnt", err_cnt, 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_err_flag", 32'(err_flag), 32'd0);
        chk("rst_last_len", 32'(last_len), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        send_pkt(64, 64);
        chk("p64_done", 32'(pkt_done), 32'd1);
        chk("p64_ok", 32'(pkt_ok), 32'd1);
        chk("p64_pkt_cnt", pkt_cnt, 32'd1);
        chk("p64_err_cnt", err_cnt, 32'd0);
        chk("p64_last_len", 32'(last_len), 32'd64);
        idle_cyc();
        chk("p64_pulse_end", 32'(pkt_done), 32'd0);

        send_pkt(13, 13);
        chk("p13_ok", 32'(pkt_ok), 32'd1);
        chk("p13_last_len", 32'(last_len), 32'd13);
        send_pkt(1, 1);
        chk("p1_done", 32'(pkt_done), 32'd1);
        chk("p1_ok", 32'(pkt_ok), 32'd1);
        chk("p1_pkt_cnt", pkt_cnt, 32'd3);
        chk("p1_last_len", 32'(last_len), 32'd1);
        idle_cyc();
        chk("p1_pulse_end", 32'(pkt_ok), 32'd0);

        send_beats(32, 32, 0, 4, 20, 8'hAA);
        chk("corr_done", 32'(pkt_done), 32'd1);
        chk("corr_ok", 32'(pkt_ok), 32'd0);
        chk("corr_code", 32'(err_code), 32'd1);
        chk("corr_flag", 32'(err_flag), 32'd1);
        chk("corr_err_cnt", err_cnt, 32'd1);
        send_pkt(16, 16);
        chk("clean_ok", 32'(pkt_ok), 32'd1);
        chk("clean_pkt_cnt", pkt_cnt, 32'd5);
        chk("clean_err_cnt", err_cnt, 32'd1);
        chk("clean_code_held", 32'(err_code), 32'd1);
        idle_cyc();

        send_pkt(48, 40);
        chk("len_ok", 32'(pkt_ok), 32'd0);
        chk("len_code", 32'(err_code), 32'd3);
        chk("len_err_cnt", err_cnt, 32'd2);
        chk("len_last_len", 32'(last_len), 32'd48);
        idle_cyc();

        drive(64'h0001_0203_0000_0000, 8'hF0, 1'b0, 16);
        chk("keep_no_early", 32'(pkt_done), 32'd0);
        drive(64'h0405_0607_0809_0A0B, 8'hFF, 1'b1, 16);
        chk("keep_done", 32'(pkt_done), 32'd1);
        chk("keep_code", 32'(err_code), 32'd2);
        chk("keep_err_cnt", err_cnt, 32'd3);
        chk("keep_pkt_cnt", pkt_cnt, 32'd7);
        idle_cyc();

        send_pkt(1500, 1500);
        chk("over_done", 32'(pkt_done), 32'd1);
        chk("over_ok", 32'(pkt_ok), 32'd0);
        chk("over_code", 32'(err_code), 32'd4);
        chk("over_err_cnt", err_cnt, 32'd4);
        chk("over_pkt_cnt", pkt_cnt, 32'd8);
        idle_cyc();

        send_beats(24, 24, 0, 2, -1, 8'h00);
`ifdef AXIS_CHK_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            idle_cyc();
            chk("tmo_wait", 32'(pkt_done), 32'd0);
        end
        idle_cyc();
        chk("tmo_done", 32'(pkt_done), 32'd1);
        chk("tmo_ok", 32'(pkt_ok), 32'd0);
        chk("tmo_code", 32'(err_code), 32'd5);
        chk("tmo_err_cnt", err_cnt, 32'd5);
        idle_cyc();
        send_pkt(8, 8);
        chk("tmo_next_ok", 32'(pkt_ok), 32'd1);
        chk("tmo_next_cnt", pkt_cnt, 32'd10);
`else
        for (int i = 0; i < 20; i++) begin
            idle_cyc();
            chk("gap_no_pulse", 32'(pkt_done), 32'd0);
        end
        send_beats(24, 24, 2, 3, -1, 8'h00);
        chk("gap_ok", 32'(pkt_ok), 32'd1);
        chk("gap_last_len", 32'(last_len), 32'd24);
        chk("gap_err_cnt", err_cnt, 32'd4);
        chk("gap_pkt_cnt", pkt_cnt, 32'd9);
`endif
        idle_cyc();

        send_beats(24, 24, 0, 2, -1, 8'h00);
        tvalid = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        chk("mrst_pkt_cnt", pkt_cnt, 32'd0);
        chk("mrst_err_cnt", err_cnt, 32'd0);
        chk("mrst_flag", 32'(err_flag), 32'd0);
        rst_n = 1'b1;
        send_pkt(8, 8);
        chk("mrst_next_ok", 32'(pkt_ok), 32'd1);
        chk("mrst_next_cnt", pkt_cnt, 32'd1);
        chk("mrst_next_len", 32'(last_len), 32'd8);
        idle_cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
